alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Parametrised successor to the ALU control decoder: decodes aluop/funct and executes the operation in one registered unit.
- Single-cycle ops complete in 1 cycle; multiply/divide run as iterative multi-cycle operations writing HI/LO.
- Valid/ready handshake on both sides. Sits between ID/EX operand latch and writeback mux in the datapath.

Parameters:
- WIDTH, 32, operand/result width (≥8, even).
- SHW, $clog2(WIDTH), shift-amount width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept this cycle.
- aluop  in  3  100 add(lw/sw/addi), 111 sub(beq), 101 and(andi), 110 or(ori), 010 R-type.
- funct  in  6  R-type function code; ignored unless aluop=010.
- opa  in  WIDTH  operand A (rs).
- opb  in  WIDTH  operand B (rt/imm).
- shamt  in  SHW  shift amount.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  result.
- zero  out  1  result==0.
- illegal  out  1  undefined aluop/funct on this result.
- div_zero  out  1  divide by zero on this result.
- busy  out  1  multi-cycle op in progress.

Behaviour:
- Reset: state=IDLE; out_valid, result, zero, illegal, div_zero, busy, HI, LO all 0; in_ready=1 once reset deasserted.
- Accept when in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready).
- R-type funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt signed, 101011 sltu.
  - 000000 sll, 000010 srl, 000011 sra (by shamt); 010000 mfhi, 010010 mflo.
  - 011000 mult, 011001 multu, 011010 div, 011011 divu.
- Add/sub wrap modulo 2^WIDTH; no overflow trap. slt/sltu give result 1 or 0.
- Single-cycle ops: result registered; out_valid rises the cycle after accept (latency 1).
- mfhi/mflo read HI/LO current at accept.
- Illegal code (aluop 000/001/011, or unlisted funct): result=0, illegal=1, latency 1, HI/LO unchanged.
- FSM states IDLE, MUL, DIV, FIN:
  - IDLE→MUL on mult/multu; IDLE→DIV on div/divu with opb≠0.
  - MUL, DIV: WIDTH iterations, one bit per cycle, internal counter WIDTH-1 down to 0. MUL is shift-add on magnitudes; DIV is restoring on magnitudes.
  - MUL/DIV→FIN when counter reaches 0.
  - FIN applies sign correction, writes HI/LO, sets out_valid, result=LO, → IDLE.
- Multi-cycle latency: out_valid exactly WIDTH+2 cycles after accept (34 at WIDTH=32). busy=1 in MUL/DIV/FIN.
- Signed multiply: {HI,LO} = 2·WIDTH-bit two's-complement product.
- Signed divide: quotient truncates toward zero, remainder takes dividend's sign. LO=quotient, HI=remainder.
- div/divu with opb=0: no iteration; latency 1; LO=all ones, HI=opa, div_zero=1.
- Most-negative ÷ −1 (signed): LO=opa, HI=0, no flag.
- Output stall: while out_valid && !out_ready, result and flags hold and no new accept occurs. A multi-cycle op may not start until its result slot is free.
- Back-to-back: with out_ready=1 continuously, single-cycle ops sustain one per cycle.
- Reset mid-operation: immediate abort; HI/LO return to 0; no out_valid is produced.
- zero is computed from the registered result.

Decomposition:
- Shared package alu_pkg:
  - aluop encodings and funct constants;
  - FSM state enum;
  - internal op enum (ADD, SUB, AND, OR, NOR, SLT, SLTU, SLL, SRL, SRA, MFHI, MFLO, MUL, MULU, DIV, DIVU, ILL).
- Sub-module alu_op_decode: combinational aluop/funct → internal op enum plus illegal flag. This replaces the old control table.
- Iterative multiply/divide datapath stays inside alu_exec_unit.

Test Plan:
- Reset, then aluop=010 funct=100101, opa=0x0000_00F0, opb=0x0000_000F, out_ready=1 → next cycle result=0x0000_00FF, out_valid=1, zero=0.
- aluop=111, opa=opb=0x1234_5678 → result=0, zero=1 after 1 cycle.
- Issue slt with opa=0xFFFF_FFFF, opb=1 → result=1. Issue sltu with the same operands → result=0.
- mult opa=0xFFFF_FFFE (−2), opb=3 → out_valid at cycle 34, result=LO=0xFFFF_FFFA, then mfhi → 0xFFFF_FFFF.
  - Also check in_ready=0 throughout cycles 1–34.
- div opa=0xFFFF_FFF9 (−7), opb=2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
  - Also divu opa=7, opb=0 → 1 cycle later LO=0xFFFF_FFFF, HI=7, div_zero=1.
- Hold out_ready=0 for 5 cycles after an add result → result stable and in_ready=0.
  - Separately, assert reset at cycle 10 of a mult → out_valid never rises, HI=LO=0, and a new op is accepted right after reset.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the ALU execute unit.
//   - aluop encodings from the main control unit and R-type funct codes
//   - FSM state enum (exposed on the debug port)
//   - internal operation enum produced by alu_op_decode
package alu_pkg;

    localparam logic [2:0] ALUOP_ADD   = 3'b100;
    localparam logic [2:0] ALUOP_SUB   = 3'b111;
    localparam logic [2:0] ALUOP_AND   = 3'b101;
    localparam logic [2:0] ALUOP_OR    = 3'b110;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIN} alu_state_t;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLTU,
        OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO,
        OP_MUL, OP_MULU, OP_DIV, OP_DIVU, OP_ILL
    } alu_op_t;

    function automatic logic op_is_mul(input alu_op_t op);
        return (op == OP_MUL) || (op == OP_MULU);
    endfunction

    function automatic logic op_is_div(input alu_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: operand/result bundle of the ALU execute unit.
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both 1. The producer holds valid and its payload stable until
// that edge; ready may change freely and never depends on valid of the
// same channel combinationally in a way that creates a loop.
//   master: issuer (ID/EX side) and result consumer (writeback side)
//   slave : the execute unit
// dbg_state exposes the unit's FSM state for observation.
interface alu_exec_unit_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       aluop;
    logic [5:0]       funct;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
    logic             div_zero;
    logic             busy;
    alu_state_t       dbg_state;

    modport master (
        output in_valid, aluop, funct, opa, opb, shamt, out_ready,
        input  in_ready, out_valid, result, zero, illegal, div_zero, busy, dbg_state
    );

    modport slave (
        input  in_valid, aluop, funct, opa, opb, shamt, out_ready,
        output in_ready, out_valid, result, zero, illegal, div_zero, busy, dbg_state
    );
endinterface

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational translation of aluop/funct into the
// internal operation enum.
//   aluop, funct : from main control / instruction
//   op           : internal operation (OP_ILL for undefined codes)
//   illegal      : 1 when the code is undefined
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0] aluop,
    input  logic [5:0] funct,
    output alu_op_t    op,
    output logic       illegal
);
    always_comb begin
        op = OP_ILL;
        unique case (aluop)
            ALUOP_ADD: op = OP_ADD;
            ALUOP_SUB: op = OP_SUB;
            ALUOP_AND: op = OP_AND;
            ALUOP_OR:  op = OP_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD:   op = OP_ADD;
                    FN_SUB:   op = OP_SUB;
                    FN_AND:   op = OP_AND;
                    FN_OR:    op = OP_OR;
                    FN_NOR:   op = OP_NOR;
                    FN_SLT:   op = OP_SLT;
                    FN_SLTU:  op = OP_SLTU;
                    FN_SLL:   op = OP_SLL;
                    FN_SRL:   op = OP_SRL;
                    FN_SRA:   op = OP_SRA;
                    FN_MFHI:  op = OP_MFHI;
                    FN_MFLO:  op = OP_MFLO;
                    FN_MULT:  op = OP_MUL;
                    FN_MULTU: op = OP_MULU;
                    FN_DIV:   op = OP_DIV;
                    FN_DIVU:  op = OP_DIVU;
                    default:  op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
    end

    assign illegal = (op == OP_ILL);
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: decodes aluop/funct and executes in one registered unit.
// Single-cycle ops produce a result one cycle after accept. mult/multu/
// div/divu iterate one bit per cycle on operand magnitudes (shift-add /
// restoring), then a FIN cycle applies sign correction and writes HI/LO.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : operand/result handshake bundle (slave side)
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
)(
    input  logic              clk,
    input  logic              reset,
    alu_exec_unit_if.slave    bus
);
    localparam int AW = 2*WIDTH + 1;

    alu_state_t       state;
    logic [WIDTH-1:0] hi, lo, result_q;
    logic             out_valid_q, zero_q, illegal_q, div_zero_q;
    logic [AW-1:0]    acc;        // mul: {partial(W+1), multiplier}; div: {rem(W+1), quotient}
    logic [WIDTH-1:0] b_q;        // multiplicand / divisor magnitude
    logic [SHW-1:0]   count;
    logic             neg_q, neg_r;

    alu_op_t op;
    logic    dec_illegal;

    alu_op_decode u_dec (.aluop(bus.aluop), .funct(bus.funct), .op(op), .illegal(dec_illegal));

    logic in_ready, accept, multi, dz;
    assign in_ready = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign dz       = op_is_div(op) && (bus.opb == '0);
    assign multi    = op_is_mul(op) || (op_is_div(op) && !dz);

    // Single-cycle result
    logic [WIDTH-1:0] sc_result;
    always_comb begin
        sc_result = '0;
        case (op)
            OP_ADD:  sc_result = bus.opa + bus.opb;
            OP_SUB:  sc_result = bus.opa - bus.opb;
            OP_AND:  sc_result = bus.opa & bus.opb;
            OP_OR:   sc_result = bus.opa | bus.opb;
            OP_NOR:  sc_result = ~(bus.opa | bus.opb);
            OP_SLT:  sc_result[0] = $signed(bus.opa) < $signed(bus.opb);
            OP_SLTU: sc_result[0] = bus.opa < bus.opb;
            OP_SLL:  sc_result = bus.opb << bus.shamt;
            OP_SRL:  sc_result = bus.opb >> bus.shamt;
            OP_SRA:  sc_result = $signed(bus.opb) >>> bus.shamt;
            OP_MFHI: sc_result = hi;
            OP_MFLO: sc_result = lo;
            OP_DIV, OP_DIVU: sc_result = '1;  // only reached with a zero divisor
            default: sc_result = '0;
        endcase
    end

    // Operand magnitudes taken at accept; signed ops only
    logic             sgn_op;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign sgn_op = (op == OP_MUL) || (op == OP_DIV);
    assign a_mag  = (sgn_op && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
    assign b_mag  = (sgn_op && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;

    // One iteration of each algorithm
    logic [WIDTH:0]  mul_sum, div_shift, div_diff;
    logic [AW-1:0]   mul_next, div_next;
    always_comb begin
        mul_sum   = acc[0] ? (acc[AW-1:WIDTH] + {1'b0, b_q}) : acc[AW-1:WIDTH];
        mul_next  = {1'b0, mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_next  = div_diff[WIDTH] ? {div_shift, acc[WIDTH-2:0], 1'b0}
                                    : {div_diff,  acc[WIDTH-2:0], 1'b1};
    end

    // Sign correction for FIN
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    always_comb begin
        prod_fix = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    logic fin_div;  // FIN came from DIV rather than MUL

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            hi          <= '0;
            lo          <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            acc         <= '0;
            b_q         <= '0;
            count       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            fin_div     <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready)
                out_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (multi) begin
                            state   <= op_is_mul(op) ? ST_MUL : ST_DIV;
                            acc     <= {{(WIDTH+1){1'b0}}, a_mag};
                            b_q     <= b_mag;
                            count   <= SHW'(WIDTH-1);
                            neg_q   <= sgn_op && (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
                            neg_r   <= sgn_op && bus.opa[WIDTH-1];
                            fin_div <= op_is_div(op);
                        end else begin
                            result_q    <= sc_result;
                            zero_q      <= (sc_result == '0);
                            illegal_q   <= dec_illegal;
                            div_zero_q  <= dz;
                            out_valid_q <= 1'b1;
                            if (dz) begin
                                lo <= '1;
                                hi <= bus.opa;
                            end
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc <= (state == ST_MUL) ? mul_next : div_next;
                    if (count == '0)
                        state <= ST_FIN;
                    else
                        count <= count - SHW'(1);
                end
                ST_FIN: begin
                    if (fin_div) begin
                        hi       <= rem_fix;
                        lo       <= quo_fix;
                        result_q <= quo_fix;
                        zero_q   <= (quo_fix == '0);
                    end else begin
                        hi       <= prod_fix[2*WIDTH-1:WIDTH];
                        lo       <= prod_fix[WIDTH-1:0];
                        result_q <= prod_fix[WIDTH-1:0];
                        zero_q   <= (prod_fix[WIDTH-1:0] == '0);
                    end
                    illegal_q   <= 1'b0;
                    div_zero_q  <= 1'b0;
                    out_valid_q <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit (WIDTH=32).
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_exec_unit_if #(.WIDTH(W)) bus();
    alu_exec_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;
    int stall_cycles = 0;

    logic [W+2:0] exp_q[$];      // {div_zero, illegal, zero, result}
    logic [W-1:0] m_hi, m_lo;    // reference HI/LO

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W+2:0] model(input logic [2:0] op, input logic [5:0] fn,
                                           input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [4:0] sh);
        logic [W-1:0] r;
        logic ill, dz;
        logic signed [63:0] sa, sb, sp;
        logic [63:0] up;
        r = '0; ill = 1'b0; dz = 1'b0;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            3'b100: r = a + b;
            3'b111: r = a - b;
            3'b101: r = a & b;
            3'b110: r = a | b;
            3'b010: begin
                case (fn)
                    6'b100000: r = a + b;
                    6'b100010: r = a - b;
                    6'b100100: r = a & b;
                    6'b100101: r = a | b;
                    6'b100111: r = ~(a | b);
                    6'b101010: r = (sa < sb) ? 32'd1 : 32'd0;
                    6'b101011: r = (a < b) ? 32'd1 : 32'd0;
                    6'b000000: r = b << sh;
                    6'b000010: r = b >> sh;
                    6'b000011: begin sp = sb >>> sh; r = sp[31:0]; end
                    6'b010000: r = m_hi;
                    6'b010010: r = m_lo;
                    6'b011000: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; r = m_lo; end
                    6'b011001: begin up = {32'd0, a} * {32'd0, b}; m_hi = up[63:32]; m_lo = up[31:0]; r = m_lo; end
                    6'b011010, 6'b011011: begin
                        if (b == 0) begin
                            dz = 1'b1; m_lo = '1; m_hi = a; r = m_lo;
                        end else if (fn == 6'b011010) begin
                            sp = sa / sb; m_lo = sp[31:0];
                            sp = sa % sb; m_hi = sp[31:0];
                            r = m_lo;
                        end else begin
                            m_lo = a / b; m_hi = a % b; r = m_lo;
                        end
                    end
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        return {dz, ill, (r == 0), r};
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [2:0] op, input logic [5:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] sh);
        int waited;
        waited = 0;
        bus.aluop = op; bus.funct = fn; bus.opa = a; bus.opb = b; bus.shamt = sh;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) chk("accept_timeout", 0, 1);
        else exp_q.push_back(model(op, fn, a, b, sh));
        stall_cycles += waited;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
            else chk("sb_result", {bus.div_zero, bus.illegal, bus.zero, bus.result}, exp_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got=running expected=done");
        $fatal(1);
    end

    logic [2:0] tab_op[16] = '{3'b100, 3'b111, 3'b101, 3'b110, 3'b010, 3'b010, 3'b010, 3'b010,
                               3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b010};
    logic [5:0] tab_fn[16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'b100000, 6'b100010, 6'b100100, 6'b100101,
                               6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011,
                               6'b100000, 6'b111111};
    logic [5:0] md_fn[4] = '{6'b011000, 6'b011001, 6'b011010, 6'b011011};

    // ---------------- test sequence ----------------
    initial begin
        int first, rdy_bad, bad, busy1;
        logic [W-1:0] a, b, held;
        m_hi = '0; m_lo = '0;
        bus.in_valid = 0; bus.aluop = 0; bus.funct = 0; bus.opa = 0; bus.opb = 0; bus.shamt = 0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_zero", bus.zero, 0);
        chk("rst_flags", {bus.illegal, bus.div_zero, bus.busy}, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_state", bus.dbg_state, ST_IDLE);
        @(posedge clk); #1;

        // R-type or, latency 1
        send(3'b010, 6'b100101, 32'h0000_00F0, 32'h0000_000F, 0);
        @(negedge clk);
        chk("or_latency", {bus.out_valid, bus.result}, {1'b1, 32'h0000_00FF});
        @(posedge clk); #1;
        send(3'b111, 6'h00, 32'h1234_5678, 32'h1234_5678, 0);
        send(3'b010, 6'b101010, 32'hFFFF_FFFF, 32'd1, 0);
        send(3'b010, 6'b101011, 32'hFFFF_FFFF, 32'd1, 0);
        drain();

        // back-to-back single-cycle burst
        stall_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 15);
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            send(tab_op[k], tab_fn[k], a, b, 5'($urandom_range(0, 31)));
        end
        chk("b2b_stalls", stall_cycles, 0);
        send(3'b011, 6'h00, 32'd1, 32'd2, 0);
        drain();

        // mult -2*3 with output held off
        bus.out_ready = 1'b0;
        send(3'b010, 6'b011000, 32'hFFFF_FFFE, 32'd3, 0);
        first = 0; rdy_bad = 0; busy1 = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) busy1 = bus.busy;
            if (bus.out_valid && first == 0) first = c;
            if (c <= 34 && bus.in_ready) rdy_bad++;
        end
        chk("mult_latency", first, 34);
        chk("mult_in_ready", rdy_bad, 0);
        chk("mult_busy", busy1, 1);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        send(3'b010, 6'b010000, 0, 0, 0);
        send(3'b010, 6'b011010, 32'hFFFF_FFF9, 32'd2, 0);
        send(3'b010, 6'b010000, 0, 0, 0);
        send(3'b010, 6'b011011, 32'd7, 32'd0, 0);
        @(negedge clk);
        chk("divz_latency", {bus.out_valid, bus.div_zero}, 2'b11);
        @(posedge clk); #1;
        send(3'b010, 6'b010000, 0, 0, 0);
        send(3'b010, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        send(3'b010, 6'b010000, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            a = $urandom();
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom() >> $urandom_range(0, 28);
            send(3'b010, md_fn[$urandom_range(0, 3)], a, b, 0);
            send(3'b010, 6'b010000, 0, 0, 0);
        end
        drain();

        // output stall hold
        bus.out_ready = 1'b0;
        send(3'b100, 6'h00, 32'd5, 32'd6, 0);
        bad = 0;
        held = bus.result;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.result !== held || bus.in_ready) bad++;
        end
        chk("stall_hold", bad, 0);
        chk("stall_value", held, 32'd11);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        drain();

        // reset in the middle of a mult
        send(3'b010, 6'b011001, $urandom(), $urandom() | 32'h1, 0);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        m_hi = '0; m_lo = '0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_state", {bus.busy, bus.out_valid, bus.in_ready}, 3'b001);
        @(posedge clk); #1;
        stall_cycles = 0;
        send(3'b010, 6'b010000, 0, 0, 0);
        send(3'b010, 6'b010010, 0, 0, 0);
        chk("rst_accept", stall_cycles, 0);
        drain();
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.out_valid) bad++;
        end
        chk("rst_no_out", bad, 0);
        chk("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
